// File: rtl/core_pkg.sv
// Shared types and constants for the instruction sequencer: FSM states,
// control-flow opcodes, flag reset value and small decode helpers.
package core_pkg;

  typedef enum logic [2:0] {
    S_HALTED    = 3'd0,
    S_FETCH     = 3'd1,
    S_FETCH_IMM = 3'd2,
    S_DECODE    = 3'd3,
    S_EXEC      = 3'd4
  } seq_state_e;

  localparam logic [3:0] OP_BR    = 4'hC;
  localparam logic [3:0] OP_JMP   = 4'hD;
  localparam logic [3:0] OP_JMPI0 = 4'hE;
  localparam logic [3:0] OP_JMPI1 = 4'hF;

  // Ordered {n, z, p}
  localparam logic [2:0] FLAGS_RESET = 3'b010;

  function automatic logic [15:0] sext8(input logic [7:0] v);
    return {{8{v[7]}}, v};
  endfunction

  function automatic logic is_imm_op(input logic [3:0] op);
    return (op == OP_JMPI0) || (op == OP_JMPI1);
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Instruction-memory and execute-unit handshake bundle. The sequencer drives
// the master side; memory and execute datapath sit on the slave side.
interface pc_sequencer_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic [15:0] instr;
  logic        exec_start;
  logic        exec_done;
  logic        exec_wr;
  logic [15:0] exec_result;

  modport master (
    output imem_req, imem_addr, instr, exec_start,
    input  imem_ack, imem_rdata, exec_done, exec_wr, exec_result
  );

  modport slave (
    input  imem_req, imem_addr, instr, exec_start,
    output imem_ack, imem_rdata, exec_done, exec_wr, exec_result
  );
endinterface

// File: rtl/next_ip_calc.sv
// Combinational next-IP computation for sequential, branch, relative-jump and
// absolute-jump instructions. Relative offsets are based on the instruction's own IP.
module next_ip_calc
  import core_pkg::*;
(
  input  logic [15:0] ip,
  input  logic [15:0] instr,
  input  logic [15:0] imm,
  input  logic        n,
  input  logic        z,
  input  logic        p,
  output logic [15:0] target
);

  logic [15:0] w_off;
  logic [15:0] w_rel;
  logic        w_taken;

  // Select target by opcode; instr[8] picks offset direction
  always_comb begin
    w_off   = sext8(instr[7:0]);
    w_rel   = instr[8] ? (ip + w_off) : (ip - w_off);
    w_taken = (instr[11] & n) | (instr[10] & z) | (instr[9] & p);
    case (instr[15:12])
      OP_BR:              target = w_taken ? w_rel : (ip + 16'd1);
      OP_JMP:             target = w_rel;
      OP_JMPI0, OP_JMPI1: target = imm;
      default:            target = ip + 16'd1;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Instruction sequencer: owns IP, instruction register and NZP flags, and runs
// the fetch/decode/execute loop over the memory and execute handshakes.
module pc_sequencer
  import core_pkg::*;
#(
  parameter logic [15:0] RESET_IP = 16'h0000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic          halt_req,
  pc_sequencer_if.master bus,
  output logic [15:0]   ip,
  output logic          n,
  output logic          z,
  output logic          p,
  output logic          halted
);

  seq_state_e  r_state, w_state_next;
  logic [15:0] r_ip, w_ip_next;
  logic [15:0] r_instr, w_instr_next;
  logic [15:0] r_imm, w_imm_next;
  logic        r_n, r_z, r_p;
  logic [2:0]  w_flags_next;
  logic        r_imem_req, w_imem_req_next;
  logic [15:0] r_imem_addr, w_imem_addr_next;
  logic        r_exec_start, w_exec_start_next;
  logic        r_halted, w_halted_next;
  logic [15:0] w_target;
  logic [15:0] w_fetch_ip;
  logic        w_enter_fetch;
  logic        w_halt_now;

  next_ip_calc u_next_ip (
    .ip     (r_ip),
    .instr  (r_instr),
    .imm    (r_imm),
    .n      (r_n),
    .z      (r_z),
    .p      (r_p),
    .target (w_target)
  );

  // Next-state and next-output logic; outputs are registered one edge later
  always_comb begin
    w_state_next      = r_state;
    w_ip_next         = r_ip;
    w_instr_next      = r_instr;
    w_imm_next        = r_imm;
    w_flags_next      = {r_n, r_z, r_p};
    w_imem_req_next   = 1'b0;
    w_imem_addr_next  = r_imem_addr;
    w_exec_start_next = 1'b0;
    w_fetch_ip        = r_ip;
    case (r_state)
      S_HALTED: begin
        if (run) begin
          w_state_next = S_FETCH;
        end else begin
          w_state_next = S_HALTED;
        end
      end
      S_FETCH: begin
        if (r_imem_req && bus.imem_ack) begin
          w_instr_next = bus.imem_rdata;
          if (is_imm_op(bus.imem_rdata[15:12])) begin
            w_state_next     = S_FETCH_IMM;
            w_imem_req_next  = 1'b1;
            w_imem_addr_next = r_ip + 16'd1;
          end else begin
            w_state_next = S_DECODE;
          end
        end else begin
          w_imem_req_next = 1'b1;
        end
      end
      S_FETCH_IMM: begin
        if (r_imem_req && bus.imem_ack) begin
          w_imm_next   = bus.imem_rdata;
          w_state_next = S_DECODE;
        end else begin
          w_imem_req_next = 1'b1;
        end
      end
      S_DECODE: begin
        case (r_instr[15:12])
          OP_BR, OP_JMP, OP_JMPI0, OP_JMPI1: begin
            w_ip_next    = w_target;
            w_fetch_ip   = w_target;
            w_state_next = S_FETCH;
          end
          default: begin
            w_exec_start_next = 1'b1;
            w_state_next      = S_EXEC;
          end
        endcase
      end
      S_EXEC: begin
        if (bus.exec_done) begin
          if (bus.exec_wr) begin
            w_flags_next = {bus.exec_result[15], bus.exec_result == 16'h0000,
                            ~bus.exec_result[15] & (bus.exec_result != 16'h0000)};
          end else begin
            w_flags_next = {r_n, r_z, r_p};
          end
          w_ip_next    = r_ip + 16'd1;
          w_fetch_ip   = r_ip + 16'd1;
          w_state_next = S_FETCH;
        end else begin
          w_state_next = S_EXEC;
        end
      end
      default: w_state_next = S_HALTED;
    endcase
    // halt_req is only honoured at an instruction boundary, i.e. on FETCH entry
    w_enter_fetch    = (w_state_next == S_FETCH) && (r_state != S_FETCH);
    w_halt_now       = w_enter_fetch && halt_req;
    w_imem_req_next  = w_imem_req_next | (w_enter_fetch & ~halt_req);
    w_imem_addr_next = w_enter_fetch ? w_fetch_ip : w_imem_addr_next;
    w_state_next     = w_halt_now ? S_HALTED : w_state_next;
    w_halted_next    = (w_state_next == S_HALTED);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_HALTED;
      r_ip         <= RESET_IP;
      r_instr      <= 16'h0000;
      r_imm        <= 16'h0000;
      {r_n, r_z, r_p} <= FLAGS_RESET;
      r_imem_req   <= 1'b0;
      r_imem_addr  <= 16'h0000;
      r_exec_start <= 1'b0;
      r_halted     <= 1'b1;
    end else begin
      r_state      <= w_state_next;
      r_ip         <= w_ip_next;
      r_instr      <= w_instr_next;
      r_imm        <= w_imm_next;
      {r_n, r_z, r_p} <= w_flags_next;
      r_imem_req   <= w_imem_req_next;
      r_imem_addr  <= w_imem_addr_next;
      r_exec_start <= w_exec_start_next;
      r_halted     <= w_halted_next;
    end
  end

  assign bus.imem_req   = r_imem_req;
  assign bus.imem_addr  = r_imem_addr;
  assign bus.instr      = r_instr;
  assign bus.exec_start = r_exec_start;
  assign ip             = r_ip;
  assign n              = r_n;
  assign z              = r_z;
  assign p              = r_p;
  assign halted         = r_halted;

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Instruction-sequencing controller for the 16-bit core. Owns the instruction pointer (IP), instruction register and NZP condition flags. Runs the fetch/decode/execute loop against the instruction memory and the execute unit through req/ack handshakes, and computes the next IP for sequential, branch, relative-jump and absolute-jump instructions. Sits between the instruction memory port and the ALU/execute datapath.

## Interface
Parameters:
- RESET_IP, 16'h0000, IP value loaded on reset.

Ports:
- clk  in  1  single system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- run  in  1  start pulse; sampled only in HALTED.
- halt_req  in  1  stop at the next instruction boundary.
- imem_req  out  1  instruction-memory read request.
- imem_addr  out  16  read address; stable while imem_req=1.
- imem_ack  in  1  read-complete strobe; imem_rdata valid in the same cycle.
- imem_rdata  in  16  read data.
- instr  out  16  current instruction register.
- exec_start  out  1  one-cycle pulse; instr is valid for the execute unit.
- exec_done  in  1  execute unit has finished.
- exec_wr  in  1  qualifies exec_done; the result updates the flags.
- exec_result  in  16  execute result, used for flag generation.
- ip  out  16  current IP.
- n, z, p  out  1 each  condition flags.
- halted  out  1  high in the HALTED state.

## Operation
- States: HALTED, FETCH, FETCH_IMM, DECODE, EXEC.
- Reset values: state=HALTED, ip=RESET_IP, instr=0, n=0, z=1, p=0, imem_req=0, exec_start=0, halted=1.
- HALTED:
  - run=1 and halt_req=0 → FETCH.
  - halt_req=1 wins over a simultaneous run.
- FETCH:
  - On entry, halt_req=1 → HALTED.
  - Otherwise imem_req=1 with imem_addr=ip.
  - On imem_ack, latch instr=imem_rdata.
  - Next state: FETCH_IMM if opcode (instr[15:12]) is 1110 or 1111, else DECODE.
- FETCH_IMM:
  - imem_req=1 with imem_addr=ip+1.
  - On imem_ack, latch imm=imem_rdata → DECODE.
- DECODE: compute the next IP from opcode = instr[15:12]:
  - 1100 BR: taken = (instr[11]&n)|(instr[10]&z)|(instr[9]&p). If taken, instr[8]=1 → ip+sext(instr[7:0]), instr[8]=0 → ip−sext(instr[7:0]). Not taken → ip+1. Then → FETCH.
  - 1101 JMP: unconditional, same offset/direction rule as BR. Then → FETCH.
  - 1110, 1111: ip=imm. Then → FETCH.
  - Any other opcode: pulse exec_start → EXEC.
- Offset base is the IP of the branch/jump instruction itself, not ip+1.
- EXEC: wait for exec_done.
  - On exec_done, if exec_wr=1: n=exec_result[15], z=(exec_result==0), p=~n&~z. If exec_wr=0, flags are unchanged.
  - ip=ip+1 → FETCH.
- Control-flow opcodes never assert exec_start and never change the flags.
- Arithmetic is 16-bit modulo 2^16 (0xFFFF+1=0x0000; 0x0002−4=0xFFFE). sext is 8→16 bit two's complement.

## Timing
- imem_req rises the cycle after the FETCH/FETCH_IMM entry edge. It stays high with a stable imem_addr until the cycle imem_ack=1, and drops the next cycle.
- imem_ack may arrive in the first request cycle (zero wait states).
- imem_ack while imem_req=0 is ignored.
- exec_done outside EXEC is ignored. exec_done in the same cycle as the exec_start pulse is accepted.
- Minimum latencies, with zero-wait memory and immediate done:
  - ALU instruction: 3 cycles (FETCH, DECODE, EXEC).
  - BR/JMP: 2 cycles.
  - 1110/1111: 3 cycles.
- halt_req is checked only at FETCH entry. An in-flight instruction always completes.
- rst mid-handshake: all outputs return to their reset values on the next edge. Any later imem_ack or exec_done is ignored.
- BR with nzp=000 is never taken; nzp=111 is always taken. An offset of 0 gives target=ip, a legal self-loop.

## Structure
- Shared package `core_pkg`:
  - State enum.
  - Opcode constants: OP_BR=4'hC, OP_JMP=4'hD, OP_JMPI0=4'hE, OP_JMPI1=4'hF.
  - Flag reset constant.
- Sub-module `next_ip_calc`: purely combinational. Inputs: ip, instr, imm, n, z, p. Output: target. The FSM and all registers stay in pc_sequencer.

## Test plan
- Reset, then run: imem_addr=0x0000. ALU instr 0x1234 with exec_result=0x8000 and exec_wr=1 → n=1, z=0, p=0, ip=0x0001.
- BR 0xC90A (n, dir=+, off=10) at ip=0x0010 with n=1 → ip=0x001A. Same instruction with only p=1 → ip=0x0011. No exec_start in either case.
- JMP 0xD0FE (dir=−, off=0xFE=−2) at ip=0x0005 → ip=0x0007. JMP 0xD103 at ip=0xFFFE → ip=0x0001 (wrap).
- 0xE000 at ip=0x0020, second word 0x4000 → imem_addr=0x0021 on the second request, then ip=0x4000.
- imem_ack delayed 3 cycles → imem_req and imem_addr stay stable for 4 cycles. A stray ack while imem_req=0 leaves the state unchanged.
- halt_req asserted mid-EXEC → the instruction completes, then halted=1 with ip incremented. rst asserted during FETCH_IMM → reset values on the next edge and imem_req=0.
